execute_stage: RTL and testbench

- Execute (EX) stage of the pipelined ARM core, between the ID/EX pipeline register and the memory stage.
- Selects operands through the forwarding muxes and the immediate mux, then computes the ALU result.
- Holds the NZCV flag register and evaluates the ARM condition field.
- Registers its results into the EX/MEM pipeline register.

---
 rtl/execute_stage.sv | 161 ++++++++++++++++
 tb/tb_execute_stage.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
// Module : execute_stage
// Desc   : ARM EX stage - operand forwarding, ALU, NZCV flags, condition check,
//          EX/MEM pipeline register.
// Rev    : 1.0
// ============================================================================
module execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] dataRegAIn,
    input  logic [WIDTH-1:0] dataRegBIn,
    input  logic [WIDTH-1:0] extIn,
    input  logic [WIDTH-1:0] ResultW,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic             ALUSrcE,
    input  logic [3:0]       ALUControlE,
    input  logic             FlagWriteE,
    input  logic [3:0]       CondE,
    input  logic             RegWriteE,
    input  logic             MemToRegE,
    input  logic             MemWriteE,
    input  logic             BranchE,
    input  logic             PCSrcE,
    input  logic [3:0]       WA3E,
    output logic [WIDTH-1:0] ALUResultE,
    output logic             BranchTakenE,
    output logic [3:0]       flagsE,
    output logic             RegWriteM,
    output logic             MemToRegM,
    output logic             MemWriteM,
    output logic             PCSrcM,
    output logic [3:0]       WA3M,
    output logic [WIDTH-1:0] ALUResultM,
    output logic [WIDTH-1:0] WriteDataM
);
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] fwd_b;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [WIDTH:0]   rsb_full;
    logic [WIDTH-1:0] result;
    logic             c_new;
    logic             v_new;
    logic [3:0]       flags_q;
    logic             fn, fz, fc, fv;
    logic             cond_ex;

    // Forwarding: codes 10 and 11 both take the EX/MEM result.
    always_comb begin
        case (ForwardAE)
            2'b00:   src_a = dataRegAIn;
            2'b01:   src_a = ResultW;
            default: src_a = ALUResultM;
        endcase
        case (ForwardBE)
            2'b00:   fwd_b = dataRegBIn;
            2'b01:   fwd_b = ResultW;
            default: fwd_b = ALUResultM;
        endcase
        src_b = ALUSrcE ? extIn : fwd_b;
    end

    // One extra MSB captures carry-out (ADD) or borrow (SUB/RSB).
    assign add_full = {1'b0, src_a} + {1'b0, src_b};
    assign sub_full = {1'b0, src_a} - {1'b0, src_b};
    assign rsb_full = {1'b0, src_b} - {1'b0, src_a};

    always_comb begin
        result = '0;
        c_new  = flags_q[1];
        v_new  = flags_q[0];
        case (ALUControlE)
            4'b0000: begin
                result = add_full[WIDTH-1:0];
                c_new  = add_full[WIDTH];
                v_new  = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                         (result[WIDTH-1] != src_a[WIDTH-1]);
            end
            4'b0001: begin
                result = sub_full[WIDTH-1:0];
                c_new  = ~sub_full[WIDTH];
                v_new  = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                         (result[WIDTH-1] != src_a[WIDTH-1]);
            end
            4'b0101: begin
                result = rsb_full[WIDTH-1:0];
                c_new  = ~rsb_full[WIDTH];
                v_new  = (src_b[WIDTH-1] != src_a[WIDTH-1]) &&
                         (result[WIDTH-1] != src_b[WIDTH-1]);
            end
            4'b0010: result = src_a & src_b;
            4'b0011: result = src_a | src_b;
            4'b0100: result = src_a ^ src_b;
            4'b0110: result = src_b;
            4'b0111: result = ~src_b;
            4'b1000: result = src_a & ~src_b;
            4'b1001: result = src_a << src_b[4:0];
            4'b1010: result = src_a >> src_b[4:0];
            4'b1011: result = $unsigned($signed(src_a) >>> src_b[4:0]);
            default: result = '0;
        endcase
    end

    assign ALUResultE = result;
    assign {fn, fz, fc, fv} = flags_q;

    // Condition uses the flags as they stood before this instruction.
    always_comb begin
        cond_ex = 1'b1;
        case (CondE)
            4'b0000: cond_ex = fz;
            4'b0001: cond_ex = ~fz;
            4'b0010: cond_ex = fc;
            4'b0011: cond_ex = ~fc;
            4'b0100: cond_ex = fn;
            4'b0101: cond_ex = ~fn;
            4'b0110: cond_ex = fv;
            4'b0111: cond_ex = ~fv;
            4'b1000: cond_ex = fc & ~fz;
            4'b1001: cond_ex = ~fc | fz;
            4'b1010: cond_ex = (fn == fv);
            4'b1011: cond_ex = (fn != fv);
            4'b1100: cond_ex = ~fz & (fn == fv);
            4'b1101: cond_ex = fz | (fn != fv);
            default: cond_ex = 1'b1;
        endcase
    end

    assign BranchTakenE = BranchE & cond_ex;
    assign flagsE       = flags_q;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            flags_q    <= '0;
            RegWriteM  <= 1'b0;
            MemToRegM  <= 1'b0;
            MemWriteM  <= 1'b0;
            PCSrcM     <= 1'b0;
            WA3M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
        end else begin
            if (FlagWriteE && cond_ex) begin
                flags_q <= {result[WIDTH-1], (result == '0), c_new, v_new};
            end
            RegWriteM  <= RegWriteE & cond_ex;
            MemToRegM  <= MemToRegE;
            MemWriteM  <= MemWriteE & cond_ex;
            PCSrcM     <= PCSrcE & cond_ex;
            WA3M       <= WA3E;
            ALUResultM <= result;
            WriteDataM <= fwd_b;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_execute_stage
// Desc   : Scoreboard bench for execute_stage: directed scenarios + model run.
// Rev    : 1.0
// ============================================================================
module tb_execute_stage;
    logic        Clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] dataRegAIn, dataRegBIn, extIn, ResultW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        ALUSrcE, FlagWriteE;
    logic [3:0]  ALUControlE, CondE, WA3E;
    logic        RegWriteE, MemToRegE, MemWriteE, BranchE, PCSrcE;
    logic [31:0] ALUResultE, ALUResultM, WriteDataM;
    logic        BranchTakenE;
    logic [3:0]  flagsE, WA3M;
    logic        RegWriteM, MemToRegM, MemWriteM, PCSrcM;

    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic        mw;
        logic        pcs;
        logic [3:0]  wa3;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [3:0]  fl;
    } em_t;

    em_t exp_q[$];
    em_t got, exp_v;
    int  vectors = 0;
    int  miscompares = 0;

    localparam longint S_MAX = 64'sd2147483647;
    localparam longint S_MIN = -64'sd2147483648;

    execute_stage #(.WIDTH(32)) dut (
        .Clk(Clk), .reset(reset),
        .dataRegAIn(dataRegAIn), .dataRegBIn(dataRegBIn), .extIn(extIn), .ResultW(ResultW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ALUSrcE(ALUSrcE),
        .ALUControlE(ALUControlE), .FlagWriteE(FlagWriteE), .CondE(CondE),
        .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
        .BranchE(BranchE), .PCSrcE(PCSrcE), .WA3E(WA3E),
        .ALUResultE(ALUResultE), .BranchTakenE(BranchTakenE), .flagsE(flagsE),
        .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
        .PCSrcM(PCSrcM), .WA3M(WA3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic em_t mk(input logic rw, m2r, mw, pcs, input logic [3:0] wa3,
                               input logic [31:0] alu, wd, input logic [3:0] fl);
        em_t e;
        e.rw = rw; e.m2r = m2r; e.mw = mw; e.pcs = pcs;
        e.wa3 = wa3; e.alu = alu; e.wd = wd; e.fl = fl;
        return e;
    endfunction

    function automatic em_t sample_m();
        return mk(RegWriteM, MemToRegM, MemWriteM, PCSrcM, WA3M, ALUResultM, WriteDataM, flagsE);
    endfunction

    // Reference ALU: flags from widened unsigned/signed arithmetic.
    function automatic void ref_alu(input logic [31:0] a, b, input logic [3:0] ctl,
                                    input logic [3:0] fl, output logic [31:0] r,
                                    output logic [3:0] nf);
        logic   c, v;
        longint s, ss;
        c = fl[1];
        v = fl[0];
        r = 32'd0;
        case (ctl)
            4'd0: begin
                s = longint'(a) + longint'(b);
                r = s[31:0]; c = s[32];
                ss = longint'($signed(a)) + longint'($signed(b));
                v = (ss > S_MAX) || (ss < S_MIN);
            end
            4'd1: begin
                r = a - b; c = (a >= b);
                ss = longint'($signed(a)) - longint'($signed(b));
                v = (ss > S_MAX) || (ss < S_MIN);
            end
            4'd5: begin
                r = b - a; c = (b >= a);
                ss = longint'($signed(b)) - longint'($signed(a));
                v = (ss > S_MAX) || (ss < S_MIN);
            end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd6:  r = b;
            4'd7:  r = ~b;
            4'd8:  r = a & ~b;
            4'd9:  r = a << b[4:0];
            4'd10: r = a >> b[4:0];
            4'd11: r = $unsigned($signed(a) >>> b[4:0]);
            default: r = 32'd0;
        endcase
        nf = {r[31], (r == 32'd0), c, v};
    endfunction

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] fl);
        logic n, z, c, v;
        {n, z, c, v} = fl;
        case (cond)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_idle();
        dataRegAIn = '0; dataRegBIn = '0; extIn = '0; ResultW = '0;
        ForwardAE = 2'b00; ForwardBE = 2'b00; ALUSrcE = 1'b0;
        ALUControlE = 4'b0000; FlagWriteE = 1'b0; CondE = 4'b1110;
        RegWriteE = 1'b0; MemToRegE = 1'b0; MemWriteE = 1'b0;
        BranchE = 1'b0; PCSrcE = 1'b0; WA3E = 4'd0;
    endtask

    task automatic test_reset();
        set_idle();
        repeat (2) @(posedge Clk);
        #1;
        got = sample_m();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL reset_initial: got %h expected 0", got);
        end
        #2 reset = 1'b1;
        // MVN of 0 gives all ones and sets N
        ALUControlE = 4'b0111; ALUSrcE = 1'b1; extIn = 32'd0; dataRegBIn = 32'h77;
        FlagWriteE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5;
        exp_q.push_back(mk(1, 0, 0, 0, 4'd5, 32'hFFFF_FFFF, 32'h77, 4'b1000));
        tick();
        got = sample_m(); exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL reset_preload: got %h expected %h", got, exp_v);
        end
        #3 reset = 1'b0;
        #1;
        got = sample_m();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL reset_async_clear: got %h expected 0", got);
        end
        vectors++;
        if (ALUResultE !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL reset_comb_alu: got %h expected ffffffff", ALUResultE);
        end
        ForwardAE = 2'b10; ALUControlE = 4'b0000; extIn = 32'd5;
        #1;
        vectors++;
        if (ALUResultE !== 32'd5) begin
            miscompares++;
            $display("FAIL reset_fwd10_zero: got %h expected 5", ALUResultE);
        end
        tick();
        got = sample_m();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL reset_held_edge: got %h expected 0", got);
        end
        #2 reset = 1'b1;
        #1;
        got = sample_m();
        vectors++;
        if (got !== '0) begin
            miscompares++;
            $display("FAIL reset_release_noedge: got %h expected 0", got);
        end
    endtask

    task automatic test_sub();
        set_idle();
        dataRegAIn = 32'd5; dataRegBIn = 32'd2; ALUControlE = 4'b0001;
        FlagWriteE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd1;
        #1;
        vectors++;
        if (ALUResultE !== 32'd3) begin
            miscompares++;
            $display("FAIL sub_alu_e: got %h expected 3", ALUResultE);
        end
        exp_q.push_back(mk(1, 0, 0, 0, 4'd1, 32'd3, 32'd2, 4'b0010));
        tick();
        got = sample_m(); exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL sub_m: got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_forwarding();
        set_idle();
        ResultW = 32'h10; ForwardAE = 2'b01; extIn = 32'd1; ALUSrcE = 1'b1;
        dataRegBIn = 32'h99; RegWriteE = 1'b1; WA3E = 4'd2;
        #1;
        vectors++;
        if (ALUResultE !== 32'h11) begin
            miscompares++;
            $display("FAIL fwd_resultw: got %h expected 11", ALUResultE);
        end
        exp_q.push_back(mk(1, 0, 0, 0, 4'd2, 32'h11, 32'h99, 4'b0010));
        tick();
        got = sample_m(); exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL fwd_m1: got %h expected %h", got, exp_v);
        end
        set_idle();
        dataRegAIn = 32'h11; ForwardBE = 2'b10; ALUControlE = 4'b0001;
        RegWriteE = 1'b1; WA3E = 4'd3;
        #1;
        vectors++;
        if (ALUResultE !== 32'd0) begin
            miscompares++;
            $display("FAIL fwd_aluresultm: got %h expected 0", ALUResultE);
        end
        exp_q.push_back(mk(1, 0, 0, 0, 4'd3, 32'd0, 32'h11, 4'b0010));
        tick();
        got = sample_m(); exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL fwd_m2: got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_conditional();
        set_idle();
        dataRegAIn = 32'd2; dataRegBIn = 32'd2; ALUControlE = 4'b0001; FlagWriteE = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 4'd0, 32'd0, 32'd2, 4'b0110));
        tick();
        got = sample_m(); exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL cond_setz: got %h expected %h", got, exp_v);
        end
        set_idle();
        CondE = 4'b0000; RegWriteE = 1'b1; WA3E = 4'd4; ALUControlE = 4'b0110;
        ALUSrcE = 1'b1; extIn = 32'd5; dataRegBIn = 32'h33; BranchE = 1'b1;
        #1;
        vectors++;
        if (BranchTakenE !== 1'b1) begin
            miscompares++;
            $display("FAIL cond_eq_branch: got %b expected 1", BranchTakenE);
        end
        exp_q.push_back(mk(1, 0, 0, 0, 4'd4, 32'd5, 32'h33, 4'b0110));
        tick();
        got = sample_m(); exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL cond_eq_m: got %h expected %h", got, exp_v);
        end
        CondE = 4'b0001; MemWriteE = 1'b1; PCSrcE = 1'b1; MemToRegE = 1'b1;
        FlagWriteE = 1'b1; WA3E = 4'd6;
        #1;
        vectors++;
        if (BranchTakenE !== 1'b0) begin
            miscompares++;
            $display("FAIL cond_ne_branch: got %b expected 0", BranchTakenE);
        end
        exp_q.push_back(mk(0, 1, 0, 0, 4'd6, 32'd5, 32'h33, 4'b0110));
        tick();
        got = sample_m(); exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL cond_ne_m: got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_overflow();
        set_idle();
        dataRegAIn = 32'h7FFF_FFFF; dataRegBIn = 32'd1; FlagWriteE = 1'b1;
        #1;
        vectors++;
        if (ALUResultE !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL ovf_alu_e: got %h expected 80000000", ALUResultE);
        end
        exp_q.push_back(mk(0, 0, 0, 0, 4'd0, 32'h8000_0000, 32'd1, 4'b1001));
        tick();
        got = sample_m(); exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL ovf_signed: got %h expected %h", got, exp_v);
        end
        dataRegAIn = 32'hFFFF_FFFF;
        exp_q.push_back(mk(0, 0, 0, 0, 4'd0, 32'd0, 32'd1, 4'b0110));
        tick();
        got = sample_m(); exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL ovf_carry: got %h expected %h", got, exp_v);
        end
    endtask

    task automatic test_branch();
        set_idle();
        dataRegAIn = 32'd1; dataRegBIn = 32'd2; ALUControlE = 4'b0001; FlagWriteE = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 4'd0, 32'hFFFF_FFFF, 32'd2, 4'b1000));
        tick();
        got = sample_m(); exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL br_setn: got %h expected %h", got, exp_v);
        end
        set_idle();
        BranchE = 1'b1; CondE = 4'b1011;
        #1;
        vectors++;
        if (BranchTakenE !== 1'b1) begin
            miscompares++;
            $display("FAIL br_lt_taken: got %b expected 1", BranchTakenE);
        end
        BranchE = 1'b0;
        #1;
        vectors++;
        if (BranchTakenE !== 1'b0) begin
            miscompares++;
            $display("FAIL br_nobranch: got %b expected 0", BranchTakenE);
        end
        set_idle();
        dataRegAIn = 32'h7FFF_FFFF; dataRegBIn = 32'd1; FlagWriteE = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 0, 4'd0, 32'h8000_0000, 32'd1, 4'b1001));
        tick();
        got = sample_m(); exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL br_setnv: got %h expected %h", got, exp_v);
        end
        set_idle();
        BranchE = 1'b1; CondE = 4'b1011;
        #1;
        vectors++;
        if (BranchTakenE !== 1'b0) begin
            miscompares++;
            $display("FAIL br_lt_not: got %b expected 0", BranchTakenE);
        end
        CondE = 4'b1010;
        #1;
        vectors++;
        if (BranchTakenE !== 1'b1) begin
            miscompares++;
            $display("FAIL br_ge_taken: got %b expected 1", BranchTakenE);
        end
    endtask

    task automatic test_random();
        logic [31:0] m_alu, srca, bf, srcb, r;
        logic [3:0]  m_fl, nf;
        logic        ok;
        em_t         e;
        set_idle();
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        m_alu = 32'd0;
        m_fl  = 4'd0;
        for (int i = 0; i < 300; i++) begin
            dataRegAIn  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            dataRegBIn  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
            extIn       = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            ResultW     = $urandom();
            ForwardAE   = 2'($urandom_range(0, 3));
            ForwardBE   = 2'($urandom_range(0, 3));
            ALUSrcE     = 1'($urandom_range(0, 1));
            ALUControlE = 4'($urandom_range(0, 15));
            FlagWriteE  = ($urandom_range(0, 3) != 0);
            CondE       = 4'($urandom_range(0, 15));
            RegWriteE   = 1'($urandom_range(0, 1));
            MemToRegE   = 1'($urandom_range(0, 1));
            MemWriteE   = 1'($urandom_range(0, 1));
            BranchE     = 1'($urandom_range(0, 1));
            PCSrcE      = 1'($urandom_range(0, 1));
            WA3E        = 4'($urandom_range(0, 15));
            srca = (ForwardAE == 2'b00) ? dataRegAIn : (ForwardAE == 2'b01) ? ResultW : m_alu;
            bf   = (ForwardBE == 2'b00) ? dataRegBIn : (ForwardBE == 2'b01) ? ResultW : m_alu;
            srcb = ALUSrcE ? extIn : bf;
            ref_alu(srca, srcb, ALUControlE, m_fl, r, nf);
            ok = cond_pass(CondE, m_fl);
            e = mk(RegWriteE & ok, MemToRegE, MemWriteE & ok, PCSrcE & ok, WA3E, r, bf,
                   (FlagWriteE && ok) ? nf : m_fl);
            exp_q.push_back(e);
            #1;
            vectors++;
            if (ALUResultE !== r) begin
                miscompares++;
                $display("FAIL rand_alu_e[%0d]: got %h expected %h ctl=%h", i, ALUResultE, r, ALUControlE);
            end
            vectors++;
            if (BranchTakenE !== (BranchE & ok)) begin
                miscompares++;
                $display("FAIL rand_branch[%0d]: got %b expected %b", i, BranchTakenE, BranchE & ok);
            end
            tick();
            got = sample_m(); exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                miscompares++;
                $display("FAIL rand_m[%0d]: got %h expected %h", i, got, exp_v);
            end
            m_alu = e.alu;
            m_fl  = e.fl;
        end
    endtask

    initial begin
        set_idle();
        reset = 1'b0;
        test_reset();
        test_sub();
        test_forwarding();
        test_conditional();
        test_overflow();
        test_branch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
